// File: rtl/strided_rd_sched.sv
// strided_rd_sched: read-side sequencer for the column ring buffer.
// Waits for a KxK window of columns, issues per-beat read addresses and
// hands column credits back to the loader as windows are consumed.
// Optional build macro STRIDED_RD_PERF_EN adds stall/starve cycle counters.
module strided_rd_sched #(
    parameter int N_BUF_X    = 5,
    parameter int B_BUF_ADDR = 9,
    parameter int B_SHAPE    = 32,
    parameter int B_COORD    = 10,
    parameter int K          = 3,
    parameter int LOG2_CPW   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [B_SHAPE-1:0]            shape,
    input  logic [1:0]                    stride,
    input  logic                          col_wr_done,
    output logic                          col_free,
    output logic [3:0]                    col_free_n,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [B_BUF_ADDR*N_BUF_X-1:0] rdaddr,
    output logic [2:0]                    bank_base,
    output logic [N_BUF_X-1:0]            bank_mask,
    output logic                          beat_last,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
`ifdef STRIDED_RD_PERF_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   starve_cycles
`endif
);

    localparam int AW = B_BUF_ADDR + 2;
    localparam logic [B_COORD-1:0] K_C    = B_COORD'(K);
    localparam logic [B_COORD-1:0] K_LAST = B_COORD'(K - 1);
    localparam logic [B_COORD-1:0] ONE_C  = B_COORD'(1);
    localparam logic [3:0]         K_AV   = 4'(K);
    localparam logic [3:0]         N_AV   = 4'(N_BUF_X);
    localparam logic [21:0]        ADDR_SPACE = 22'(1) << B_BUF_ADDR;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_COLS, S_ISSUE, S_COL_DONE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                rd_valid_q, rd_valid_d;
    logic                col_free_q, col_free_d;
    logic [3:0]          col_free_n_q, col_free_n_d;
    logic                cfg_err_q, cfg_err_d;
    logic [B_COORD-1:0]  n_cw_q, n_cw_d, w_q, w_d, ow_q, ow_d, oh_q, oh_d;
    logic [1:0]          stride_q, stride_d;
    logic [AW-1:0]       step_q, step_d, line_base_q, line_base_d, row_base_q, row_base_d;
    logic [B_COORD-1:0]  ox_q, ox_d, oy_q, oy_d, ky_q, ky_d, cw_q, cw_d;
    logic [B_COORD-1:0]  col_pos_q, col_pos_d, cols_written_q, cols_written_d;
    logic [3:0]          col_avail_q, col_avail_d;
    logic [2:0]          bank_base_q, bank_base_d;

    logic [11:0]         c_in, n_cw_full;
    logic [B_COORD-1:0]  h_in, w_in, w_span, h_span, n_cw_new, last_n;
    logic [21:0]         cfg_words;
    logic                cfg_bad, handshake, beat_last_int, wr_inc;
    logic [AW-1:0]       addr_full;
    logic [3:0]          release_n, bank_sum;
    logic [4:0]          avail_sum;
    logic [N_BUF_X-1:0]  mask_full;
    logic                unused_bits;

    assign c_in      = shape[31:20];
    assign h_in      = shape[19:10];
    assign w_in      = shape[9:0];
    assign n_cw_full = c_in >> LOG2_CPW;
    assign n_cw_new  = n_cw_full[B_COORD-1:0];
    assign cfg_words = 22'(h_in) * 22'(n_cw_full);
    assign w_span    = w_in - K_C;
    assign h_span    = h_in - K_C;
    // Stride 3 cannot be divided without a divider, so it is rejected like stride 0.
    assign cfg_bad   = (n_cw_full == 12'd0) || (stride == 2'd0) || (stride == 2'd3) ||
                       (w_in < K_C) || (h_in < K_C) || (cfg_words > ADDR_SPACE);

    assign handshake     = rd_valid_q & rd_ready;
    assign beat_last_int = (cw_q == n_cw_q - ONE_C) && (ky_q == K_LAST) && (oy_q == oh_q - ONE_C);
    assign addr_full     = line_base_q + AW'(cw_q);
    assign bank_sum      = {1'b0, bank_base_q} + {2'b00, stride_q};
    assign last_n        = w_q - col_pos_q;
    assign wr_inc        = col_wr_done && (state_q != S_IDLE);
    assign unused_bits   = ^{n_cw_full[11:B_COORD], addr_full[AW-1:B_BUF_ADDR], last_n[B_COORD-1:4]};

    // Window occupancy: K consecutive banks starting at bank_base, wrapping around the ring.
    always_comb begin
        mask_full = '0;
        for (int b = 0; b < N_BUF_X; b++) begin
            for (int i = 0; i < K; i++) begin
                if ((int'(bank_base_q) + i == b) || (int'(bank_base_q) + i == b + N_BUF_X)) begin
                    mask_full[b] = 1'b1;
                end
            end
        end
    end

    // Next-state logic: job setup, beat walking, credit release and column accounting.
    always_comb begin
        state_d        = state_q;
        rd_valid_d     = rd_valid_q;
        col_free_d     = 1'b0;
        col_free_n_d   = 4'd0;
        cfg_err_d      = cfg_err_q;
        n_cw_d         = n_cw_q;
        w_d            = w_q;
        stride_d       = stride_q;
        step_d         = step_q;
        ow_d           = ow_q;
        oh_d           = oh_q;
        ox_d           = ox_q;
        oy_d           = oy_q;
        ky_d           = ky_q;
        cw_d           = cw_q;
        line_base_d    = line_base_q;
        row_base_d     = row_base_q;
        col_pos_d      = col_pos_q;
        bank_base_d    = bank_base_q;
        release_n      = 4'd0;
        cols_written_d = cols_written_q;
        if (wr_inc && (cols_written_q != '1)) begin
            cols_written_d = cols_written_q + ONE_C;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_err_d = cfg_bad;
                    n_cw_d    = n_cw_new;
                    w_d       = w_in;
                    stride_d  = stride;
                    step_d    = (stride == 2'd2) ? (AW'(n_cw_new) << 1) : AW'(n_cw_new);
                    ow_d      = ((stride == 2'd2) ? (w_span >> 1) : w_span) + ONE_C;
                    oh_d      = ((stride == 2'd2) ? (h_span >> 1) : h_span) + ONE_C;
                    state_d   = cfg_bad ? S_DONE : S_WAIT_COLS;
                end
            end
            S_WAIT_COLS: begin
                if (col_avail_q >= K_AV) begin
                    state_d    = S_ISSUE;
                    rd_valid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    if (beat_last_int) begin
                        rd_valid_d  = 1'b0;
                        state_d     = S_COL_DONE;
                        cw_d        = '0;
                        ky_d        = '0;
                        oy_d        = '0;
                        line_base_d = '0;
                        row_base_d  = '0;
                    end else if (cw_q != n_cw_q - ONE_C) begin
                        cw_d = cw_q + ONE_C;
                    end else begin
                        cw_d = '0;
                        if (ky_q != K_LAST) begin
                            ky_d        = ky_q + ONE_C;
                            line_base_d = line_base_q + AW'(n_cw_q);
                        end else begin
                            ky_d        = '0;
                            oy_d        = oy_q + ONE_C;
                            row_base_d  = row_base_q + step_q;
                            line_base_d = row_base_q + step_q;
                        end
                    end
                end
            end
            S_COL_DONE: begin
                if (ox_q != ow_q - ONE_C) begin
                    col_free_d   = 1'b1;
                    col_free_n_d = {2'b00, stride_q};
                    release_n    = {2'b00, stride_q};
                    bank_base_d  = (bank_sum >= N_AV) ? 3'(bank_sum - N_AV) : bank_sum[2:0];
                    col_pos_d    = col_pos_q + B_COORD'(stride_q);
                    ox_d         = ox_q + ONE_C;
                    state_d      = S_WAIT_COLS;
                end else if (cols_written_q == w_q) begin
                    col_free_d   = 1'b1;
                    col_free_n_d = last_n[3:0];
                    release_n    = last_n[3:0];
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                ox_d        = '0;
                col_pos_d   = '0;
                bank_base_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        avail_sum = {1'b0, col_avail_q} + 5'(wr_inc) - 5'(release_n);
        if (avail_sum[4]) begin
            col_avail_d = '0;
        end else if (avail_sum[3:0] > N_AV) begin
            col_avail_d = N_AV;
        end else begin
            col_avail_d = avail_sum[3:0];
        end
        if (state_q == S_DONE) begin
            col_avail_d    = '0;
            cols_written_d = '0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rd_valid_q     <= 1'b0;
            col_free_q     <= 1'b0;
            col_free_n_q   <= '0;
            cfg_err_q      <= 1'b0;
            n_cw_q         <= '0;
            w_q            <= '0;
            stride_q       <= '0;
            step_q         <= '0;
            ow_q           <= '0;
            oh_q           <= '0;
            ox_q           <= '0;
            oy_q           <= '0;
            ky_q           <= '0;
            cw_q           <= '0;
            line_base_q    <= '0;
            row_base_q     <= '0;
            col_pos_q      <= '0;
            cols_written_q <= '0;
            col_avail_q    <= '0;
            bank_base_q    <= '0;
        end else begin
            state_q        <= state_d;
            rd_valid_q     <= rd_valid_d;
            col_free_q     <= col_free_d;
            col_free_n_q   <= col_free_n_d;
            cfg_err_q      <= cfg_err_d;
            n_cw_q         <= n_cw_d;
            w_q            <= w_d;
            stride_q       <= stride_d;
            step_q         <= step_d;
            ow_q           <= ow_d;
            oh_q           <= oh_d;
            ox_q           <= ox_d;
            oy_q           <= oy_d;
            ky_q           <= ky_d;
            cw_q           <= cw_d;
            line_base_q    <= line_base_d;
            row_base_q     <= row_base_d;
            col_pos_q      <= col_pos_d;
            cols_written_q <= cols_written_d;
            col_avail_q    <= col_avail_d;
            bank_base_q    <= bank_base_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rdaddr     = rd_valid_q ? {N_BUF_X{addr_full[B_BUF_ADDR-1:0]}} : '0;
    assign bank_mask  = rd_valid_q ? mask_full : '0;
    assign beat_last  = rd_valid_q & beat_last_int;
    assign bank_base  = bank_base_q;
    assign col_free   = col_free_q;
    assign col_free_n = col_free_n_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign cfg_err    = cfg_err_q;

`ifdef STRIDED_RD_PERF_EN
    logic [31:0] stall_q, stall_d, starve_q, starve_d;

    // Back-pressure and column-starvation counters, restarted by each new job.
    always_comb begin
        stall_d  = stall_q + 32'(rd_valid_q & ~rd_ready);
        starve_d = starve_q + 32'(state_q == S_WAIT_COLS);
        if ((state_q == S_IDLE) && start) begin
            stall_d  = '0;
            starve_d = '0;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_strided_rd_sched.sv
// Testbench for strided_rd_sched: directed jobs plus randomized jobs, compared
// against a window-walk reference model and a credit-driven loader model.
module tb_strided_rd_sched;

    localparam int N_BUF_X    = 5;
    localparam int B_BUF_ADDR = 9;
    localparam int K          = 3;

    logic        clk = 1'b0;
    logic        rst, start, col_wr_done, rd_ready;
    logic [31:0] shape;
    logic [1:0]  stride;
    logic        col_free, rd_valid, beat_last, busy, done, cfg_err;
    logic [3:0]  col_free_n;
    logic [B_BUF_ADDR*N_BUF_X-1:0] rdaddr;
    logic [2:0]  bank_base;
    logic [N_BUF_X-1:0] bank_mask;
`ifdef STRIDED_RD_PERF_EN
    logic [31:0] stall_cycles, starve_cycles;
`endif

    strided_rd_sched dut (
        .clk(clk), .rst(rst), .start(start), .shape(shape), .stride(stride),
        .col_wr_done(col_wr_done), .col_free(col_free), .col_free_n(col_free_n),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rdaddr(rdaddr),
        .bank_base(bank_base), .bank_mask(bank_mask), .beat_last(beat_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef STRIDED_RD_PERF_EN
        , .stall_cycles(stall_cycles), .starve_cycles(starve_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] exp_beats[$];
    logic [63:0] obs_beats[$];
    int exp_free[$];
    int obs_free[$];
    int done_cnt, freed_sum, stall_obs, first_beat_cyc, done_cyc, wr3_cyc;
    bit held_valid, job_stop;
    logic [63:0] held;
    logic [63:0] cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] packBeat(input int addr, input int base, input int mask, input bit last);
        logic [8:0] a9;
        logic [2:0] b3;
        logic [4:0] m5;
        a9 = addr[8:0];
        b3 = base[2:0];
        m5 = mask[4:0];
        return {9'd0, 1'b1, {N_BUF_X{a9}}, b3, m5, last};
    endfunction

    assign cur = {9'd0, rd_valid, rdaddr, bank_base, bank_mask, beat_last};

    // Observe the DUT away from the active edge: beats, held beats, credits, done.
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) checkOutput("hold_while_stalled", cur, held);
            if (rd_valid) begin
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                if (rd_ready) begin
                    obs_beats.push_back(cur);
                    held_valid = 1'b0;
                end else begin
                    stall_obs++;
                    held_valid = 1'b1;
                    held = cur;
                end
            end else begin
                held_valid = 1'b0;
            end
            if (col_free) begin
                obs_free.push_back(int'(col_free_n));
                freed_sum += int'(col_free_n);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    end

    // Reference model: walk windows left to right, rows, kernel rows, channel words.
    task automatic buildExpect(input int c, input int h, input int w, input int s, output bit bad);
        int n_cw, ow, oh, base, mask;
        exp_beats.delete();
        exp_free.delete();
        n_cw = c >> 2;
        bad = (n_cw == 0) || (s == 0) || (s == 3) || (w < K) || (h < K) || (h * n_cw > (1 << B_BUF_ADDR));
        if (bad) return;
        ow = (w - K) / s + 1;
        oh = (h - K) / s + 1;
        for (int ox = 0; ox < ow; ox++) begin
            base = (ox * s) % N_BUF_X;
            mask = 0;
            for (int i = 0; i < K; i++) mask |= 1 << ((base + i) % N_BUF_X);
            for (int oy = 0; oy < oh; oy++)
                for (int ky = 0; ky < K; ky++)
                    for (int cw = 0; cw < n_cw; cw++)
                        exp_beats.push_back(packBeat((oy * s + ky) * n_cw + cw, base, mask,
                                            (oy == oh - 1) && (ky == K - 1) && (cw == n_cw - 1)));
            exp_free.push_back((ox < ow - 1) ? s : (w - s * (ow - 1)));
        end
    endtask

    // Loader: writes a column whenever it holds a credit, optional gap between writes.
    task automatic loaderRun(input int lw, input int gap);
        int written = 0;
        int wait_cnt = 0;
        while (!job_stop && written < lw) begin
            @(posedge clk); #1;
            col_wr_done = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else if (N_BUF_X - written + freed_sum > 0) begin
                col_wr_done = 1'b1;
                written++;
                if (written == 3) wr3_cyc = cyc;
                wait_cnt = gap;
            end
        end
        @(posedge clk); #1;
        col_wr_done = 1'b0;
    endtask

    task automatic readyRun(input int mode);
        while (!job_stop) begin
            @(posedge clk); #1;
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = ~rd_ready;
                default: rd_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
        rd_ready = 1'b1;
    endtask

    task automatic waitDone(input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        job_stop = 1'b1;
    endtask

    task automatic applyStimulus(input int c, input int h, input int w, input int s, input int mode, input int gap);
        bit bad;
        int start_edge;
        buildExpect(c, h, w, s, bad);
        obs_beats.delete();
        obs_free.delete();
        done_cnt = 0; freed_sum = 0; stall_obs = 0;
        first_beat_cyc = -1; done_cyc = -1; wr3_cyc = -1;
        job_stop = 1'b0;
        @(posedge clk); #1;
        shape = 32'((c << 20) | (h << 10) | w);
        stride = 2'(s);
        start = 1'b1;
        rd_ready = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        if (mode == 1) rd_ready = 1'b0;
        fork
            loaderRun(bad ? 0 : w, gap);
            readyRun(mode);
            waitDone(3000);
        join
        checkOutput("beat_count", 64'(obs_beats.size()), 64'(exp_beats.size()));
        for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++)
            checkOutput($sformatf("beat%0d", i), obs_beats[i], exp_beats[i]);
        checkOutput("free_count", 64'(obs_free.size()), 64'(exp_free.size()));
        for (int i = 0; i < obs_free.size() && i < exp_free.size(); i++)
            checkOutput($sformatf("col_free_n%0d", i), 64'(obs_free[i]), 64'(exp_free[i]));
        checkOutput("done_count", 64'(done_cnt), 64'd1);
        checkOutput("cfg_err", 64'(cfg_err), 64'(bad));
        if (bad) checkOutput("err_done_latency", 64'((done_cyc >= 0) && (done_cyc - start_edge <= 3)), 64'd1);
        if (!bad && gap > 0) checkOutput("no_early_beat", 64'(first_beat_cyc > wr3_cyc), 64'd1);
`ifdef STRIDED_RD_PERF_EN
        checkOutput("stall_cycles", 64'(stall_cycles), 64'(stall_obs));
        if (!bad) checkOutput("starve_nonzero", 64'(starve_cycles != 0), 64'd1);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; col_wr_done = 1'b0; rd_ready = 1'b0;
        shape = '0; stride = '0;
        done_cnt = 0; freed_sum = 0; stall_obs = 0; first_beat_cyc = -1; done_cyc = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    64'({rd_valid, col_free, col_free_n, rdaddr, bank_base, bank_mask, beat_last, busy, done, cfg_err}),
                    64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(8, 4, 4, 1, 0, 0);
        applyStimulus(8, 4, 4, 1, 0, 20);
        applyStimulus(8, 4, 4, 1, 1, 0);
        applyStimulus(4, 3, 9, 2, 0, 0);
        applyStimulus(8, 2, 4, 1, 0, 0);

        // Reset in the middle of issuing a window.
        @(posedge clk); #1;
        shape = 32'((8 << 20) | (4 << 10) | 4);
        stride = 2'd1;
        start = 1'b1;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            col_wr_done = 1'b1;
            @(posedge clk); #1;
        end
        col_wr_done = 1'b0;
        for (int i = 0; i < 30 && !rd_valid; i++) @(negedge clk);
        checkOutput("issue_reached", 64'(rd_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        obs_free.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rd_valid_busy", 64'({rd_valid, busy}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("rst_no_col_free", 64'(obs_free.size()), 64'd0);
        applyStimulus(8, 4, 4, 1, 0, 0);

        for (int j = 0; j < 8; j++) begin
            int n, c, h, w, s;
            n = $urandom_range(1, 3);
            c = n * 4 + $urandom_range(0, 3);
            h = $urandom_range(3, 6);
            w = $urandom_range(2, 12);
            s = $urandom_range(1, 2);
            applyStimulus(c, h, w, s, 2, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
